// File: rtl/btb_pkg.sv
// btb_pkg -- shared types and helpers for the branch target buffer.
//   btb_state_t : sweep FSM states (IDLE, SWEEP)
//   ctr_weak    : weakly-taken counter init value, 2^(ctr_w-1)
//   sat_inc/dec : saturating counter arithmetic for a ctr_w-bit counter
// Counters are carried in CTR_MAX_W-bit containers so one function serves
// every CTR_W; callers slice the low CTR_W bits back out.
package btb_pkg;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} btb_state_t;

   localparam int CTR_MAX_W = 8;

   function automatic logic [CTR_MAX_W-1:0] ctr_weak(input int ctr_w);
      return CTR_MAX_W'(1) << (ctr_w - 1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] c,
                                                    input int ctr_w);
      logic [CTR_MAX_W-1:0] mx;
      mx = (CTR_MAX_W'(1) << ctr_w) - CTR_MAX_W'(1);
      return (c >= mx) ? mx : c + CTR_MAX_W'(1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] c);
      return (c == '0) ? '0 : c - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/btb_if.sv
// btb_if -- fetch/write-back side bundle of the branch target buffer.
//   lookup : lk_pc -> pred_taken, pred_pc (combinational)
//   update : upd_valid, upd_pc, upd_taken, upd_target
//   control: inv_req -> busy
// master = core side driving lookups/updates, slave = the predictor.
interface btb_if #(parameter int PC_W = 16);

   logic [PC_W-1:0] lk_pc;
   logic            pred_taken;
   logic [PC_W-1:0] pred_pc;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic [PC_W-1:0] upd_target;
   logic            inv_req;
   logic            busy;

   modport master (
      output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, inv_req,
      input  pred_taken, pred_pc, busy
   );

   modport slave (
      input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, inv_req,
      output pred_taken, pred_pc, busy
   );

endinterface

// File: rtl/btb_sweep_ctl.sv
// btb_sweep_ctl -- bulk-invalidate sequencer for the BTB valid bits.
//   clk, rst_n : clock, async active-low reset (reset starts a sweep)
//   inv_req    : start / restart a sweep from index 0
//   busy       : sweep in progress
//   clr_en     : clear valid[clr_idx] this cycle
//   clr_idx    : entry being cleared
module btb_sweep_ctl
   import btb_pkg::*;
#(
   parameter  int ENTRIES = 1024,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inv_req,
   output logic             busy,
   output logic             clr_en,
   output logic [IDX_W-1:0] clr_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   btb_state_t       state, state_nxt;
   logic [IDX_W-1:0] sweep_idx, sweep_idx_nxt;

   // Reset lands in SWEEP: the table is RAM-style and holds garbage at power-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SWEEP;
         sweep_idx <= '0;
      end else begin
         state     <= state_nxt;
         sweep_idx <= sweep_idx_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sweep_idx_nxt = sweep_idx;
      busy          = (state == SWEEP);
      clr_en        = (state == SWEEP);
      clr_idx       = sweep_idx;
      if (inv_req) begin
         state_nxt     = SWEEP;
         sweep_idx_nxt = '0;
      end else if (state == SWEEP) begin
         if (sweep_idx == LAST_IDX) begin
            state_nxt     = IDLE;
            sweep_idx_nxt = '0;
         end else begin
            sweep_idx_nxt = sweep_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor -- direct-mapped branch target buffer with saturating
// counters and bulk invalidate.
//   clk, rst_n : clock, async active-low reset
//   bus        : btb_if.slave (lookup, update, invalidate, busy)
// Optional build macro BTB_TAG_EN: store and compare partial tags
// pc[IDX_W+TAG_W:IDX_W+1]; when undefined, hit = valid and TAG_W is unused.
module btb_predictor
   import btb_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int ENTRIES = 1024,
   parameter int TAG_W   = 5,
   parameter int CTR_W   = 2
) (
   input  logic clk,
   input  logic rst_n,
   btb_if.slave bus
);

   localparam int                   IDX_W     = $clog2(ENTRIES);
   localparam logic [CTR_MAX_W-1:0] WEAK_FULL = ctr_weak(CTR_W);
   localparam logic [CTR_W-1:0]     CTR_WEAK  = WEAK_FULL[CTR_W-1:0];

   // Table storage: no reset, cleared by the sweep instead.
   logic            valid  [ENTRIES];
   logic [PC_W-1:0] target [ENTRIES];
   logic [CTR_W-1:0] ctr   [ENTRIES];
`ifdef BTB_TAG_EN
   logic [TAG_W-1:0] tag   [ENTRIES];
`endif

   logic             busy, clr_en;
   logic [IDX_W-1:0] clr_idx;

   btb_sweep_ctl #(.ENTRIES(ENTRIES)) u_sweep (
      .clk     (clk),
      .rst_n   (rst_n),
      .inv_req (bus.inv_req),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_idx (clr_idx)
   );

   // ---- lookup (combinational) ----
   logic [IDX_W-1:0] lk_idx;
   logic             lk_hit;

   assign lk_idx = bus.lk_pc[IDX_W:1];
`ifdef BTB_TAG_EN
   assign lk_hit = valid[lk_idx] && (tag[lk_idx] == bus.lk_pc[IDX_W+TAG_W:IDX_W+1]);
`else
   assign lk_hit = valid[lk_idx];
`endif

   assign bus.pred_taken = lk_hit & ctr[lk_idx][CTR_W-1] & ~busy;
   assign bus.pred_pc    = bus.pred_taken ? target[lk_idx] : bus.lk_pc + PC_W'(2);
   assign bus.busy       = busy;

   // ---- update (read-modify-write, visible next cycle) ----
   logic [IDX_W-1:0]     up_idx;
   logic                 up_hit, up_en;
   logic [CTR_MAX_W-1:0] ctr_inc, ctr_dec;

   assign up_idx = bus.upd_pc[IDX_W:1];
`ifdef BTB_TAG_EN
   assign up_hit = valid[up_idx] && (tag[up_idx] == bus.upd_pc[IDX_W+TAG_W:IDX_W+1]);
`else
   assign up_hit = valid[up_idx];
`endif

   // Invalidate wins over a same-cycle update; updates during a sweep are lost.
   assign up_en   = bus.upd_valid & ~busy & ~bus.inv_req;
   assign ctr_inc = sat_inc(CTR_MAX_W'(ctr[up_idx]), CTR_W);
   assign ctr_dec = sat_dec(CTR_MAX_W'(ctr[up_idx]));

   // Clear and update never coincide: updates are gated by busy.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         valid[clr_idx] <= 1'b0;
      end else if (up_en) begin
         if (bus.upd_taken) begin
            target[up_idx] <= bus.upd_target;
            if (up_hit) begin
               ctr[up_idx] <= ctr_inc[CTR_W-1:0];
            end else begin
               valid[up_idx] <= 1'b1;
               ctr[up_idx]   <= CTR_WEAK;
`ifdef BTB_TAG_EN
               tag[up_idx]   <= bus.upd_pc[IDX_W+TAG_W:IDX_W+1];
`endif
            end
         end else if (up_hit) begin
            ctr[up_idx] <= ctr_dec[CTR_W-1:0];
         end
      end
   end

endmodule
